// File: rtl/bit_reverse_collector.sv
// bit_reverse_collector
//
// Collects ASCII '0'/'1' characters from the keyboard bit-input stage, one
// per char_valid strobe, into a WIDTH-bit word. Once the word is complete it
// is held on a valid/ready handshake in two forms: raw (bit i is the i-th
// accepted bit) and bit-reversed.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   char_in       ASCII character from the bit-input stage
//   char_valid    char_in is valid this cycle
//   char_ready    block can accept a character this cycle
//   flush         synchronous abort, discards the partial or held word
//   bit_count     bits accepted so far in the current word (WIDTH while held)
//   word_raw      assembled word, bit i = i-th accepted bit
//   word_rev      bit-reversed word, word_rev[i] = word_raw[WIDTH-1-i]
//   result_valid  word_raw/word_rev are valid
//   result_ready  downstream accepts the result
//   bad_char      one-cycle pulse after a rejected character was accepted
//
// Optional feature (macro BITREV_ERR_COUNT_EN):
//   err_count     8-bit saturating count of rejected characters, cleared by
//                 reset only

module bit_reverse_collector #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char_in,
    input  logic             char_valid,
    output logic             char_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] bit_count,
    output logic [WIDTH-1:0] word_raw,
    output logic [WIDTH-1:0] word_rev,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             bad_char
`ifdef BITREV_ERR_COUNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] next_rev;
    logic             accept;
    logic             is_bit;
    logic             word_complete;

    // Handshake decode plus next-state logic. flush overrides everything;
    // the only way out of DONE otherwise is a result transfer.
    always_comb begin
        next_state    = state;
        char_ready    = (state == COLLECT);
        result_valid  = (state == DONE);
        accept        = char_valid && (state == COLLECT);
        is_bit        = (char_in == 8'h30) || (char_in == 8'h31);
        word_complete = accept && is_bit && (bit_count == LAST_IDX);

        if (flush) begin
            next_state = COLLECT;
        end else begin
            case (state)
                COLLECT: if (word_complete) next_state = DONE;
                DONE:    if (result_ready)  next_state = COLLECT;
                default: next_state = COLLECT;
            endcase
        end
    end

    // The word as it will look once the current character is inserted at
    // position bit_count; a compare per bit avoids a variable-width index.
    always_comb begin
        next_word = shift_reg;
        next_rev  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bit_count == CNT_W'(i)) next_word[i] = char_in[0];
        end
        for (int i = 0; i < WIDTH; i++) begin
            next_rev[i] = next_word[WIDTH-1-i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= COLLECT;
        else       state <= next_state;
    end

    // Datapath. The published words are only written on completion, so they
    // stay stable through DONE and keep their last value after a transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_count <= '0;
            shift_reg <= '0;
            word_raw  <= '0;
            word_rev  <= '0;
            bad_char  <= 1'b0;
        end else begin
            bad_char <= 1'b0;
            if (flush) begin
                bit_count <= '0;
                shift_reg <= '0;
            end else if ((state == DONE) && result_ready) begin
                bit_count <= '0;
                shift_reg <= '0;
            end else if (accept) begin
                if (is_bit) begin
                    shift_reg <= next_word;
                    bit_count <= bit_count + CNT_W'(1);
                    if (word_complete) begin
                        word_raw <= next_word;
                        word_rev <= next_rev;
                    end
                end else begin
                    bad_char <= 1'b1;
                end
            end
        end
    end

`ifdef BITREV_ERR_COUNT_EN
    // Rejected-character counter; a character discarded by flush is not
    // counted, matching the suppressed bad_char pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= 8'h00;
        end else if (accept && !is_bit && !flush && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_bit_reverse_collector.sv
// tb_bit_reverse_collector
//
// Bench for bit_reverse_collector (WIDTH=8, CNT_W=4). A queue-based model of
// the collected bits predicts every output after each clock; a table of
// fixed vectors covers the basic word, and hand sequences cover bad
// characters, backpressure, flush, async reset and random traffic.

module tb_bit_reverse_collector;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [7:0]       char_in;
    logic             char_valid;
    logic             char_ready;
    logic             flush;
    logic [CNT_W-1:0] bit_count;
    logic [WIDTH-1:0] word_raw;
    logic [WIDTH-1:0] word_rev;
    logic             result_valid;
    logic             result_ready;
    logic             bad_char;
`ifdef BITREV_ERR_COUNT_EN
    logic [7:0]       err_count;
`endif

    bit_reverse_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .flush        (flush),
        .bit_count    (bit_count),
        .word_raw     (word_raw),
        .word_rev     (word_rev),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .bad_char     (bad_char)
`ifdef BITREV_ERR_COUNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bits collected so far, whether a word is held, the
    // last published word, the pending bad_char pulse and the error count.
    int q_bits[$];
    bit m_done;
    int m_word;
    bit m_bad;
    int m_err;

    typedef struct {
        logic [7:0] ch;
        logic       valid;
        logic       ready;
        logic       fl;
        logic       exp_rv;
        int         exp_cnt;
        logic       exp_bad;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int reverse_of(input int w);
        int r = 0;
        for (int i = 0; i < WIDTH; i++)
            if (((w >> i) & 1) != 0) r += 1 << (WIDTH - 1 - i);
        return r;
    endfunction

    function automatic void model_reset();
        q_bits.delete();
        m_done = 1'b0;
        m_word = 0;
        m_bad  = 1'b0;
        m_err  = 0;
    endfunction

    function automatic void model_step(input logic [7:0] ch, input logic v,
                                       input logic rdy, input logic fl);
        m_bad = 1'b0;
        if (fl) begin
            q_bits.delete();
            m_done = 1'b0;
        end else if (m_done) begin
            if (rdy) begin
                m_done = 1'b0;
                q_bits.delete();
            end
        end else if (v) begin
            if (ch == "0" || ch == "1") begin
                q_bits.push_back(ch == "1" ? 1 : 0);
                if (q_bits.size() == WIDTH) begin
                    m_word = 0;
                    foreach (q_bits[i]) m_word += q_bits[i] << i;
                    m_done = 1'b1;
                end
            end else begin
                m_bad = 1'b1;
                if (m_err < 255) m_err++;
            end
        end
    endfunction

    task automatic checkOutput();
        check("char_ready",   int'(char_ready),   int'(!m_done));
        check("result_valid", int'(result_valid), int'(m_done));
        check("bit_count",    int'(bit_count),    m_done ? WIDTH : q_bits.size());
        check("bad_char",     int'(bad_char),     int'(m_bad));
        check("word_raw",     int'(word_raw),     m_word);
        check("word_rev",     int'(word_rev),     reverse_of(m_word));
`ifdef BITREV_ERR_COUNT_EN
        check("err_count",    int'(err_count),    m_err);
`endif
    endtask

    // One clock: drive inputs away from the edge, advance the model at the
    // edge, then compare just after it.
    task automatic applyStimulus(input logic [7:0] ch, input logic v,
                                 input logic rdy, input logic fl);
        char_in      = ch;
        char_valid   = v;
        result_ready = rdy;
        flush        = fl;
        @(posedge clk);
        model_step(ch, v, rdy, fl);
        #1;
        checkOutput();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        char_in = 8'h00; char_valid = 1'b0; result_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        checkOutput();
        reset = 1'b0;
    endtask

    task automatic send_word(input int w);
        for (int i = 0; i < WIDTH; i++)
            applyStimulus(((w >> i) & 1) != 0 ? 8'h31 : 8'h30, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        char_in = 8'h00; char_valid = 1'b0; result_ready = 1'b0; flush = 1'b0;
        model_reset();

        // Basic word '0','1','0','0','1','1','1','1' -> 0xF2 / 0x4F, then a
        // strobe ignored in DONE, then a transfer.
        vecs[0] = '{8'h30, 1, 0, 0, 0, 1, 0};
        vecs[1] = '{8'h31, 1, 0, 0, 0, 2, 0};
        vecs[2] = '{8'h30, 1, 0, 0, 0, 3, 0};
        vecs[3] = '{8'h30, 1, 0, 0, 0, 4, 0};
        vecs[4] = '{8'h31, 1, 0, 0, 0, 5, 0};
        vecs[5] = '{8'h31, 1, 0, 0, 0, 6, 0};
        vecs[6] = '{8'h31, 1, 0, 0, 0, 7, 0};
        vecs[7] = '{8'h31, 1, 0, 0, 1, 8, 0};
        vecs[8] = '{8'h30, 1, 0, 0, 1, 8, 0};
        vecs[9] = '{8'h00, 0, 1, 0, 0, 0, 0};

        do_reset();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].ch, vecs[i].valid, vecs[i].ready, vecs[i].fl);
            check("vec_result_valid", int'(result_valid), int'(vecs[i].exp_rv));
            check("vec_bit_count",    int'(bit_count),    vecs[i].exp_cnt);
            check("vec_bad_char",     int'(bad_char),     int'(vecs[i].exp_bad));
            if (i == 7) begin
                check("vec_word_raw", int'(word_raw), 'hF2);
                check("vec_word_rev", int'(word_rev), 'h4F);
                check("vec_char_ready", int'(char_ready), 0);
            end
        end
        check("after_xfer_char_ready", int'(char_ready), 1);

        // Sparse repeated '1' strobes, then eight '0's.
        for (int i = 0; i < WIDTH; i++) begin
            idle($urandom_range(0, 5), 1'b0);
            applyStimulus(8'h31, 1'b1, 1'b0, 1'b0);
        end
        check("ones_raw", int'(word_raw), 'hFF);
        check("ones_rev", int'(word_rev), 'hFF);

        // Backpressure: held word stays put while '0' is offered.
        for (int i = 0; i < 10; i++) applyStimulus(8'h30, 1'b1, 1'b0, 1'b0);
        check("bp_raw", int'(word_raw), 'hFF);
        applyStimulus(8'h30, 1'b0, 1'b1, 1'b0);
        check("bp_release_count", int'(bit_count), 0);
        send_word(0);
        check("zeros_raw", int'(word_raw), 'h00);
        idle(1, 1'b1);

        // Bad character after three bits.
        applyStimulus(8'h31, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h30, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h31, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h78, 1'b1, 1'b0, 1'b0);
        check("bad_pulse", int'(bad_char), 1);
        check("bad_count_held", int'(bit_count), 3);
        applyStimulus(8'h31, 1'b1, 1'b0, 1'b0);
        check("bad_pulse_end", int'(bad_char), 0);
        for (int i = 0; i < 4; i++) applyStimulus(8'h30, 1'b1, 1'b0, 1'b0);
        check("bad_word_raw", int'(word_raw), 'h0D);
        check("bad_word_rev", int'(word_rev), 'hB0);
`ifdef BITREV_ERR_COUNT_EN
        check("err_count_one", int'(err_count), 1);
`endif
        idle(1, 1'b1);

        // Flush after five bits, then a fresh word.
        for (int i = 0; i < 5; i++) applyStimulus(8'h31, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
        check("flush_count", int'(bit_count), 0);
        send_word('hA5);
        check("fresh_raw", int'(word_raw), 'hA5);
        check("fresh_rev", int'(word_rev), 'hA5);

        // Asynchronous reset while holding a word, between clock edges.
        #2;
        reset = 1'b1;
        #1;
        check("async_rv", int'(result_valid), 0);
        check("async_count", int'(bit_count), 0);
        check("async_raw", int'(word_raw), 0);
        model_reset();
        reset = 1'b0;
        idle(1, 1'b0);

`ifdef BITREV_ERR_COUNT_EN
        // Saturation, and flush leaves the counter alone.
        for (int i = 0; i < 300; i++) applyStimulus(8'h41, 1'b1, 1'b0, 1'b0);
        check("err_sat", int'(err_count), 'hFF);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
        check("err_after_flush", int'(err_count), 'hFF);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [7:0] ch;
            r  = $urandom_range(0, 9);
            ch = (r < 4) ? 8'h30 : (r < 8) ? 8'h31 : 8'($urandom);
            applyStimulus(ch, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 29) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_reverse_collector.md
Name: bit_reverse_collector

Overview:
- Downstream consumer of the keyboard bit-input stage.
- Accepts ASCII '0'/'1' characters one per valid strobe and assembles WIDTH bits into a word.
- Presents both the raw word and its bit-reversed form on a valid/ready output handshake for the display/output stage.
- Uses an explicit char_valid strobe, so repeated identical characters are each counted.

Parameters:
- WIDTH, 8, number of bits per word (2..15).
- CNT_W, 4, width of bit_count; WIDTH must be < 2**CNT_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- char_in  input  8  ASCII character from the bit-input stage.
- char_valid  input  1  char_in is valid this cycle.
- char_ready  output  1  block can accept a character this cycle.
- flush  input  1  synchronous abort: discard partial or held word.
- bit_count  output  CNT_W  bits accepted so far in the current word.
- word_raw  output  WIDTH  assembled word; bit i is the i-th accepted bit.
- word_rev  output  WIDTH  bit-reversed word: word_rev[i] = word_raw[WIDTH-1-i].
- result_valid  output  1  word_raw/word_rev are valid.
- result_ready  input  1  downstream accepts the result.
- bad_char  output  1  one-cycle pulse: a rejected character was presented.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: state=COLLECT, bit_count=0, word_raw=0, word_rev=0, result_valid=0, bad_char=0. char_ready is 1 once reset deasserts.
- States:
  - COLLECT: char_ready=1, result_valid=0.
  - DONE: char_ready=0, result_valid=1, outputs held stable.
- Accept: occurs when char_valid & char_ready.
  - char_in=8'h30 ('0') or 8'h31 ('1'): shift register bit[bit_count] <= char_in[0]; bit_count += 1.
  - Any other value: character dropped; bit_count unchanged; bad_char=1 on the next cycle for exactly one cycle.
- Word completion: the accept that brings bit_count to WIDTH moves the state to DONE on the same edge.
  - word_raw and word_rev are registered on that edge, so result_valid is high the cycle after the final character is accepted (latency 1).
  - bit_count reads WIDTH while in DONE.
- DONE handling:
  - char_valid is ignored because char_ready=0; no bad_char is generated.
  - The upstream must hold its character until char_ready returns.
- Transfer: result_valid & result_ready at an edge moves the state to COLLECT and sets bit_count=0.
  - word_raw and word_rev keep their last values but are valid only while result_valid is high.
  - char_ready=1 in the following cycle, so there is no back-to-back accept in the transfer cycle.
- result_ready high while in COLLECT has no effect.
- flush (highest synchronous priority): next state COLLECT, bit_count=0, result_valid=0, internal shift register cleared. A char accepted in the same cycle as flush is discarded.
- Reset mid-word or mid-DONE: everything returns immediately to reset values; the partial word is lost.
- bit_count never exceeds WIDTH and never wraps.

Optional Feature:
- Macro: BITREV_ERR_COUNT_EN.
- Defined: adds output err_count (8 bits), which increments on every rejected character and saturates at 8'hFF.
  - Cleared by reset only; flush does not clear it.
- Not defined: the port and its counter are absent; bad_char behaviour is unchanged.

Test Plan:
- Basic word: after reset, present '0','1','0','0','1','1','1','1' on consecutive cycles with result_ready=0 -> result_valid=1 one cycle after the 8th accept, word_raw=8'hF2, word_rev=8'h4F, bit_count=8, char_ready=0.
- Repeated values with sparse strobes: eight '1' characters with gaps of 0-5 idle cycles between them -> every strobe counted, word_raw=word_rev=8'hFF; then '0' x8 -> 8'h00.
- Backpressure: hold result_ready=0 for 10 cycles in DONE while driving char_valid=1 with '0' -> outputs stable, no accept, bad_char=0. Raise result_ready for 1 cycle -> result_valid=0 and bit_count=0 next cycle, char_ready=1.
- Bad character: insert 'x' (8'h78) after 3 valid bits -> bad_char pulses once, bit_count stays 3, final word is unaffected. With BITREV_ERR_COUNT_EN, err_count=1.
- Flush and reset: flush after 5 bits -> bit_count=0, and the next 8 bits form a fresh word. Assert reset asynchronously while in DONE -> result_valid drops immediately, bit_count=0.
- Saturation (BITREV_ERR_COUNT_EN): 300 bad characters -> err_count=8'hFF; flush leaves it at 8'hFF.
